vend_controller: RTL and testbench

Transaction controller for the vending machine. It accumulates coin credit, arbitrates product-select buttons, and sequences a shared dispenser over a valid/done handshake. It then returns change as a train of nickel pulses. It sits between the coin/button front end and the dispenser and change-hopper drivers, and replaces the fixed-15-cent Moore FSM with a priced, multi-product controller.

---
 rtl/vend_controller.sv | 185 ++++++++++++++++++
 tb/tb_vend_controller.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/vend_controller.sv
// Priced multi-product vending transaction controller: coin credit, select arbitration,
// dispenser valid/done handshake and nickel change train. Optional watchdog: VEND_TIMEOUT_EN.
module vend_controller #(
  parameter int unsigned NUM_PRODUCTS = 4,
  parameter int unsigned PRICE        = 3,
  parameter int unsigned MAX_CREDIT   = 20,
  parameter int unsigned TIMEOUT      = 255
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              nickel,
  input  logic                              dime,
  input  logic                              cancel,
  input  logic [NUM_PRODUCTS-1:0]           sel,
  input  logic                              disp_done,
  output logic                              disp_valid,
  output logic [$clog2(NUM_PRODUCTS)-1:0]   disp_sel,
  output logic                              change_nickel,
  output logic [$clog2(MAX_CREDIT+1)-1:0]   credit,
  output logic                              coin_reject,
  output logic                              insufficient,
  output logic                              busy,
  output logic                              fault
);

  localparam int unsigned CW = $clog2(MAX_CREDIT + 1);
  localparam int unsigned SW = $clog2(NUM_PRODUCTS);
  localparam logic [CW:0]   PriceX = (CW+1)'(PRICE);
  localparam logic [CW:0]   MaxX   = (CW+1)'(MAX_CREDIT);
  localparam logic [CW-1:0] PriceC = CW'(PRICE);
  localparam logic [CW-1:0] One    = CW'(1);

  // StRelease is the cycle after disp_done (or watchdog abort) before change or idle.
  typedef enum logic [2:0] {StIdle, StCredit, StDispense, StRelease, StChange} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   credit_q, credit_d;
  logic [SW-1:0]   disp_sel_q, disp_sel_d;
  logic            disp_valid_q, disp_valid_d;
  logic            change_q, change_d;
  logic            reject_q, reject_d;
  logic            insuf_q, insuf_d;
  logic            busy_q, busy_d;
  logic            fault_q, fault_d;

  logic [CW:0]     coin_add, coin_sum;
  logic            coin_in, coin_ok, price_ok, timeout_hit;
  logic [CW-1:0]   credit_acc;
  logic [SW-1:0]   sel_idx;

`ifdef VEND_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] timer_q;

  assign timeout_hit = (timer_q == TW'(TIMEOUT - 1));

  // Holds zero outside DISPENSE, so it is clear on every entry.
  always_ff @(posedge clk) begin
    if (reset || state_q != StDispense) timer_q <= '0;
    else                                timer_q <= timer_q + TW'(1);
  end
`else
  logic unused_timeout;
  assign timeout_hit    = 1'b0;
  assign unused_timeout = ^TIMEOUT;
`endif

  // Fixed priority: lowest pressed index wins.
  always_comb begin
    sel_idx = '0;
    for (int i = NUM_PRODUCTS - 1; i >= 0; i--) begin
      if (sel[i]) sel_idx = SW'(i);
    end
  end

  // A simultaneous nickel+dime processes only the dime.
  always_comb begin
    coin_add   = dime ? (CW+1)'(2) : (nickel ? (CW+1)'(1) : '0);
    coin_in    = nickel | dime;
    coin_sum   = {1'b0, credit_q} + coin_add;
    coin_ok    = coin_in && (coin_sum <= MaxX);
    credit_acc = coin_ok ? coin_sum[CW-1:0] : credit_q;
    price_ok   = ({1'b0, credit_q} >= PriceX);
  end

  always_comb begin
    state_d      = state_q;
    credit_d     = credit_q;
    disp_sel_d   = disp_sel_q;
    disp_valid_d = 1'b0;
    change_d     = 1'b0;
    reject_d     = 1'b0;
    insuf_d      = 1'b0;
    fault_d      = 1'b0;

    unique case (state_q)
      StIdle, StCredit: begin
        reject_d = (nickel && dime) || (coin_in && !coin_ok);
        credit_d = credit_acc;
        if (coin_ok) state_d = StCredit;
        if (state_q == StCredit && cancel) begin
          // First refund nickel goes out on the same edge that enters CHANGE.
          change_d = 1'b1;
          credit_d = credit_acc - One;
          state_d  = (credit_acc == One) ? StIdle : StChange;
        end else if (|sel) begin
          if (price_ok) begin
            state_d      = StDispense;
            credit_d     = credit_acc - PriceC;
            disp_valid_d = 1'b1;
            disp_sel_d   = sel_idx;
          end else begin
            insuf_d = 1'b1;
          end
        end
      end
      StDispense: begin
        reject_d     = coin_in;
        disp_valid_d = 1'b1;
        if (disp_done) begin
          disp_valid_d = 1'b0;
          state_d      = StRelease;
        end else if (timeout_hit) begin
          disp_valid_d = 1'b0;
          fault_d      = 1'b1;
          credit_d     = credit_q + PriceC;
          state_d      = StRelease;
        end
      end
      StRelease: begin
        reject_d = coin_in;
        if (credit_q == '0) begin
          state_d = StIdle;
        end else begin
          change_d = 1'b1;
          credit_d = credit_q - One;
          state_d  = (credit_q == One) ? StIdle : StChange;
        end
      end
      StChange: begin
        reject_d = coin_in;
        change_d = 1'b1;
        credit_d = credit_q - One;
        state_d  = (credit_q == One) ? StIdle : StChange;
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d == StDispense) || (state_d == StRelease) || (state_d == StChange);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      credit_q     <= '0;
      disp_sel_q   <= '0;
      disp_valid_q <= 1'b0;
      change_q     <= 1'b0;
      reject_q     <= 1'b0;
      insuf_q      <= 1'b0;
      busy_q       <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      credit_q     <= credit_d;
      disp_sel_q   <= disp_sel_d;
      disp_valid_q <= disp_valid_d;
      change_q     <= change_d;
      reject_q     <= reject_d;
      insuf_q      <= insuf_d;
      busy_q       <= busy_d;
      fault_q      <= fault_d;
    end
  end

  assign disp_valid    = disp_valid_q;
  assign disp_sel      = disp_sel_q;
  assign change_nickel = change_q;
  assign credit        = credit_q;
  assign coin_reject   = reject_q;
  assign insufficient  = insuf_q;
  assign busy          = busy_q;
  assign fault         = fault_q;

endmodule

// File: tb/tb_vend_controller.sv
// Directed self-checking bench for vend_controller (PRICE=3, MAX_CREDIT=20, 4 products).
module tb_vend_controller;

  logic       clk = 1'b0;
  logic       reset, nickel, dime, cancel, disp_done;
  logic [3:0] sel;
  logic       disp_valid, change_nickel, coin_reject, insufficient, busy, fault;
  logic [1:0] disp_sel;
  logic [4:0] credit;

  int n_tests = 0;
  int n_fail  = 0;
  int n;

  vend_controller #(
    .NUM_PRODUCTS(4),
    .PRICE       (3),
    .MAX_CREDIT  (20),
    .TIMEOUT     (8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .nickel       (nickel),
    .dime         (dime),
    .cancel       (cancel),
    .sel          (sel),
    .disp_done    (disp_done),
    .disp_valid   (disp_valid),
    .disp_sel     (disp_sel),
    .change_nickel(change_nickel),
    .credit       (credit),
    .coin_reject  (coin_reject),
    .insufficient (insufficient),
    .busy         (busy),
    .fault        (fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    nickel = 0; dime = 0; cancel = 0; sel = '0; disp_done = 0;
  endtask

  task automatic pay(input int dimes, input int nickels);
    for (int i = 0; i < dimes; i++) begin
      dime = 1; tick(); dime = 0;
    end
    for (int i = 0; i < nickels; i++) begin
      nickel = 1; tick(); nickel = 0;
    end
  endtask

  // Counts change pulses over a bounded window; ends idle.
  task automatic drain(output int pulses);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (change_nickel) pulses++;
    end
  endtask

  initial begin
    clear_in();
    reset = 1;
    tick(); tick();
    reset = 0;
    check("rst_credit", int'(credit), 0);
    check("rst_valid", int'(disp_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_change", int'(change_nickel), 0);
    check("rst_sel", int'(disp_sel), 0);
    check("rst_fault", int'(fault), 0);

    // Exact payment
    pay(1, 1);
    check("exact_credit", int'(credit), 3);
    sel = 4'b0100; tick(); sel = '0;
    check("exact_valid", int'(disp_valid), 1);
    check("exact_sel", int'(disp_sel), 2);
    check("exact_credit0", int'(credit), 0);
    check("exact_busy", int'(busy), 1);
    tick(); tick();
    check("exact_hold", int'(disp_valid), 1);
    disp_done = 1; tick(); disp_done = 0;
    check("exact_release", int'(disp_valid), 0);
    tick();
    check("exact_idle_busy", int'(busy), 0);
    drain(n);
    check("exact_nochange", n, 0);

    // Overpay with change
    pay(4, 0);
    check("over_credit", int'(credit), 8);
    sel = 4'b0011; tick(); sel = '0;
    check("over_sel", int'(disp_sel), 0);
    check("over_credit5", int'(credit), 5);
    disp_done = 1; tick(); disp_done = 0;
    check("over_release", int'(disp_valid), 0);
    check("over_nochg_yet", int'(change_nickel), 0);
    tick();
    check("over_first_chg", int'(change_nickel), 1);
    check("over_credit4", int'(credit), 4);
    drain(n);
    check("over_pulses", n, 4);
    check("over_final", int'(credit), 0);

    // Saturation
    pay(9, 1);
    check("sat_19", int'(credit), 19);
    dime = 1; tick(); dime = 0;
    check("sat_reject", int'(coin_reject), 1);
    check("sat_hold", int'(credit), 19);
    tick();
    check("sat_reject_pulse", int'(coin_reject), 0);
    pay(0, 1);
    check("sat_20", int'(credit), 20);
    cancel = 1; tick(); cancel = 0;
    drain(n);
    check("sat_refund", n, 19);
    check("sat_final", int'(credit), 0);

    // Simultaneous coins, then insufficient select
    nickel = 1; dime = 1; tick(); nickel = 0; dime = 0;
    check("both_credit", int'(credit), 2);
    check("both_reject", int'(coin_reject), 1);
    sel = 4'b0001; tick(); sel = '0;
    check("insuf_pulse", int'(insufficient), 1);
    check("insuf_valid", int'(disp_valid), 0);
    check("insuf_credit", int'(credit), 2);
    tick();
    check("insuf_single", int'(insufficient), 0);
    cancel = 1; tick(); cancel = 0;
    check("insuf_cancel_chg", int'(change_nickel), 1);
    check("insuf_cancel_cr", int'(credit), 1);
    drain(n);
    check("insuf_refund", n, 1);

    // Cancel and busy rejection
    pay(3, 0);
    cancel = 1; tick(); cancel = 0;
    check("cancel_chg", int'(change_nickel), 1);
    check("cancel_cr", int'(credit), 5);
    check("cancel_busy", int'(busy), 1);
    nickel = 1; tick(); nickel = 0;
    check("busy_reject", int'(coin_reject), 1);
    check("busy_cr", int'(credit), 4);
    drain(n);
    check("cancel_rest", n, 4);
    check("cancel_final", int'(credit), 0);

    // Cancel beats select; coin in that cycle is refunded
    pay(1, 1);
    cancel = 1; sel = 4'b0001; nickel = 1; tick();
    cancel = 0; sel = '0; nickel = 0;
    check("cxs_valid", int'(disp_valid), 0);
    check("cxs_cr", int'(credit), 3);
    drain(n);
    check("cxs_rest", n, 3);

    // Select uses pre-coin credit; coin still accepted. disp_done at the rising edge ignored.
    pay(1, 1);
    sel = 4'b1000; dime = 1; disp_done = 1; tick();
    sel = '0; dime = 0; disp_done = 0;
    check("selcoin_sel", int'(disp_sel), 3);
    check("selcoin_cr", int'(credit), 2);
    tick();
    check("done_same_ignored", int'(disp_valid), 1);
    disp_done = 1; tick(); disp_done = 0;
    drain(n);
    check("selcoin_change", n, 2);

`ifdef VEND_TIMEOUT_EN
    pay(1, 1);
    sel = 4'b0010; tick(); sel = '0;
    for (int i = 0; i < 7; i++) tick();
    check("wd_still_valid", int'(disp_valid), 1);
    check("wd_no_fault", int'(fault), 0);
    tick();
    check("wd_fault", int'(fault), 1);
    check("wd_drop", int'(disp_valid), 0);
    check("wd_refund_cr", int'(credit), 3);
    tick();
    check("wd_fault_pulse", int'(fault), 0);
    check("wd_first_chg", int'(change_nickel), 1);
    drain(n);
    check("wd_rest", n, 2);
`else
    pay(1, 1);
    sel = 4'b0010; tick(); sel = '0;
    for (int i = 0; i < 12; i++) tick();
    check("nowd_valid", int'(disp_valid), 1);
    check("nowd_fault", int'(fault), 0);
    disp_done = 1; tick(); disp_done = 0;
    drain(n);
    check("nowd_change", n, 0);
`endif

    // Reset mid-CHANGE discards credit
    pay(2, 0);
    cancel = 1; tick(); cancel = 0;
    reset = 1; tick(); reset = 0;
    check("rst_mid_cr", int'(credit), 0);
    check("rst_mid_chg", int'(change_nickel), 0);
    check("rst_mid_busy", int'(busy), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
